synthesijer_fdiv_iter: RTL

- Parametrised iterative IEEE-754-style floating-point divider: result = a / b.
- Successor to the fixed 32-bit vendor-IP divider wrapper. Pure RTL, so no vendor core is needed.
- Generic in exponent and mantissa width: half, single or custom formats.
- Sits behind the Synthesijer scheduler, which relies on the nd/valid contract and a fixed, input-independent latency.

---
 rtl/synthesijer_fdiv_iter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/synthesijer_fdiv_iter.sv
// Iterative floating-point divider (result = a / b), flush-to-zero, round-to-nearest-even,
// fixed latency MAN_W+6. Define SYNTHESIJER_FDIV_FLAGS_EN to add the exception flags output.
module synthesijer_fdiv_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 nd,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 valid,
  output logic                 busy
`ifdef SYNTHESIJER_FDIV_FLAGS_EN
  ,
  output logic [4:0]           flags
`endif
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int Q_W   = MAN_W + 3;
  localparam int E_W   = EXP_W + 2;
  localparam int CNT_W = $clog2(Q_W + 1);

  localparam logic signed [E_W-1:0] BIAS    = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] EXP_MAX = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] ZERO_E  = '0;
  localparam logic signed [E_W-1:0] ONE_E   = E_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(Q_W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PREP  = 3'd1;
  localparam logic [2:0] DIV   = 3'd2;
  localparam logic [2:0] NORM  = 3'd3;
  localparam logic [2:0] ROUND = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [1:0] SP_NONE = 2'd0;
  localparam logic [1:0] SP_NAN  = 2'd1;
  localparam logic [1:0] SP_INF  = 2'd2;
  localparam logic [1:0] SP_ZERO = 2'd3;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [2:0]             state;
  logic [W-1:0]           a_r, b_r;
  logic [MAN_W:0]         mb;
  logic [MAN_W+1:0]       rem;
  logic [Q_W-1:0]         q;
  logic [CNT_W-1:0]       cnt;
  logic signed [E_W-1:0]  exp_t;
  logic                   sign;
  logic                   sticky;
  logic [1:0]             spec;

  // Operand classification; exponent zero covers both zero and denormal (FTZ).
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [1:0] spec_c;

  assign ea     = a_r[W-2:MAN_W];
  assign eb     = b_r[W-2:MAN_W];
  assign fa     = a_r[MAN_W-1:0];
  assign fb     = b_r[MAN_W-1:0];
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_inf  = (&ea) & ~|fa;
  assign b_inf  = (&eb) & ~|fb;
  assign a_nan  = (&ea) & |fa;
  assign b_nan  = (&eb) & |fb;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    spec_c = SP_NONE;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) spec_c = SP_NAN;
    else if (a_inf | b_zero)                                   spec_c = SP_INF;
    else if (a_zero | b_inf)                                   spec_c = SP_ZERO;
  end

  // One restoring-division step: subtract when the partial remainder covers the divisor.
  logic [MAN_W+2:0] diff;
  logic             q_bit;
  logic [MAN_W+1:0] rem_sel;

  assign diff    = {1'b0, rem} - {2'b00, mb};
  assign q_bit   = ~diff[MAN_W+2];
  assign rem_sel = q_bit ? diff[MAN_W+1:0] : rem;

  // Rounding on the normalised quotient: q = {1.mant, guard, lsb-sticky}.
  logic [MAN_W:0]        mant;
  logic                  guard, stk, rup;
  logic [MAN_W+1:0]      sum;
  logic signed [E_W-1:0] exp_f;
  logic                  ovf, unf;
  logic [MAN_W-1:0]      frac_r;
  logic [W-1:0]          round_res;

  assign mant   = q[Q_W-1:2];
  assign guard  = q[1];
  assign stk    = q[0] | sticky;
  assign rup    = guard & (stk | mant[0]);
  assign sum    = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rup};
  assign exp_f  = exp_t + $signed({{(E_W-1){1'b0}}, sum[MAN_W+1]});
  assign ovf    = exp_f >= EXP_MAX;
  assign unf    = exp_f <= ZERO_E;
  assign frac_r = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];

  always_comb begin
    round_res = '0;
    case (spec)
      SP_NAN:  round_res = QNAN;
      SP_INF:  round_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SP_ZERO: round_res = {sign, {(W-1){1'b0}}};
      default: begin
        if (ovf)      round_res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (unf) round_res = {sign, {(W-1){1'b0}}};
        else          round_res = {sign, exp_f[EXP_W-1:0], frac_r};
      end
    endcase
  end

`ifdef SYNTHESIJER_FDIV_FLAGS_EN
  logic       divz;
  logic [4:0] flags_c;
  logic       fin;

  assign fin     = (spec == SP_NONE);
  assign flags_c = {spec == SP_NAN, divz, fin & ovf, fin & ~ovf & unf,
                    fin & (guard | stk | ovf | unf)};
`endif

  // NOTE: reset is synchronous and clears every register, including the operand and datapath state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      mb     <= '0;
      rem    <= '0;
      q      <= '0;
      cnt    <= '0;
      exp_t  <= '0;
      sign   <= 1'b0;
      sticky <= 1'b0;
      spec   <= SP_NONE;
      result <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
`ifdef SYNTHESIJER_FDIV_FLAGS_EN
      divz   <= 1'b0;
      flags  <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (nd) begin
            a_r   <= a;
            b_r   <= b;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          mb     <= {1'b1, fb};
          rem    <= {2'b01, fa};
          q      <= '0;
          cnt    <= '0;
          exp_t  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          sign   <= a_r[W-1] ^ b_r[W-1];
          spec   <= spec_c;
`ifdef SYNTHESIJER_FDIV_FLAGS_EN
          divz   <= b_zero & ~a_zero & ~a_inf & ~a_nan;
`endif
          state  <= DIV;
        end
        DIV: begin
          q   <= {q[Q_W-2:0], q_bit};
          rem <= rem_sel << 1;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= NORM;
        end
        NORM: begin
          if (!q[Q_W-1]) begin
            q     <= {q[Q_W-2:0], 1'b0};
            exp_t <= exp_t - ONE_E;
          end
          sticky <= |rem;
          state  <= ROUND;
        end
        ROUND: begin
          result <= round_res;
`ifdef SYNTHESIJER_FDIV_FLAGS_EN
          flags  <= flags_c;
`endif
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
